instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/loader_pkg.sv | 20 ++
 rtl/instr_loader_if.sv | 23 ++
 rtl/word_assembler.sv | 27 ++
 rtl/instr_loader.sv | 88 ++++++++
 tb/tb_instr_loader.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam logic [7:0] CHK_SEED = 8'h00;

  // States in which the loader still consumes stream bytes.
  function automatic logic is_loading(input state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instr_loader_if #(
  parameter int ADDR_W = 32
);

  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/word_assembler.sv
// Packs little-endian payload bytes into 32-bit words and flags each completed word.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        acc,
  input  logic [7:0]  din,
  output logic [1:0]  byte_idx,
  output logic [31:0] word,
  output logic        word_vld
);

  // Bytes shift in from the top, so after four of them word = {b3,b2,b1,b0}.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word     <= '0;
      byte_idx <= '0;
      word_vld <= 1'b0;
    end else begin
      word_vld <= acc && (byte_idx == 2'd3);
      if (acc) begin
        word     <= {din, word[31:8]};
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Streams a counted, XOR-checksummed program into instruction memory, then releases the CPU.
module instr_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  instr_loader_if.master     bus,
  output logic               cpu_run,
  output logic               done,
  output logic               err
);

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [7:0]  chk;
  logic [7:0]  cnt_lo;
  logic [15:0] cnt;
  logic [15:0] widx;
  logic [15:0] hdr_cnt;
  logic        acc;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic        word_vld;

  assign bus.in_ready = reset && is_loading(state);
  assign acc          = bus.in_valid && bus.in_ready;
  assign hdr_cnt      = {bus.in_data, cnt_lo};

  word_assembler u_asm (
    .clk      (clk),
    .reset    (reset),
    .acc      (acc && (state == DATA)),
    .din      (bus.in_data),
    .byte_idx (byte_idx),
    .word     (word),
    .word_vld (word_vld)
  );

  // widx advances in the write cycle itself, so it names the word being written.
  assign bus.im_we    = word_vld;
  assign bus.im_wdata = word;
  assign bus.im_addr  = BASE_ADDR + ADDR_W'({widx, 2'b00});

  assign cpu_run = (state == DONE);
  assign done    = (state == DONE);
  assign err     = (state == ERROR);

  always_comb begin
    state_nxt = state;
    unique case (state)
      HDR_LO: if (acc) state_nxt = HDR_HI;
      HDR_HI: begin
        if (acc) begin
          if ({1'b0, hdr_cnt} > MAX_W) state_nxt = ERROR;
          else if (hdr_cnt == 16'd0)   state_nxt = CHECK;
          else                         state_nxt = DATA;
        end
      end
      DATA: begin
        if (acc && (byte_idx == 2'd3) && (widx == cnt - 16'd1)) state_nxt = CHECK;
      end
      CHECK: if (acc) state_nxt = (bus.in_data == chk) ? DONE : ERROR;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= HDR_LO;
      chk    <= CHK_SEED;
      cnt_lo <= '0;
      cnt    <= '0;
      widx   <= '0;
    end else begin
      state <= state_nxt;
      if (acc && (state != CHECK)) chk <= chk ^ bus.in_data;
      if (acc && (state == HDR_LO)) cnt_lo <= bus.in_data;
      if (acc && (state == HDR_HI)) cnt <= hdr_cnt;
      if (word_vld) widx <= widx + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed and randomized program streams checked against a stream-level loader model.
module tb_instr_loader;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam int          MAXW   = 256;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cpu_run, done, err;

  instr_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_loader #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .cpu_run (cpu_run),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          c;
  } wr_t;

  wr_t seen[$];
  int  acc_cyc[$];

  always @(negedge clk) begin
    if (bus.im_we === 1'b1) seen.push_back('{bus.im_addr, bus.im_wdata, cyc});
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    64'(bus.im_we),    64'(0));
    check({tag, "_addr"},  64'(bus.im_addr),  64'(BASE));
    check({tag, "_wdata"}, 64'(bus.im_wdata), 64'(0));
    check({tag, "_run"},   64'(cpu_run),      64'(0));
    check({tag, "_done"},  64'(done),         64'(0));
    check({tag, "_err"},   64'(err),          64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Offers one byte, optionally after idle cycles; records whether it will be taken.
  task automatic drive_byte(input logic [7:0] b, input int gap_pct);
    int n = 0;
    while ((n < 3) && (int'($urandom_range(99)) < gap_pct)) begin
      @(negedge clk);
      #1;
      bus.in_valid = 1'b0;
      n++;
    end
    @(negedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    if (bus.in_ready === 1'b1) acc_cyc.push_back(cyc);
  endtask

  task automatic make_stream(input int cnt, input bit bad, input int extra,
                             output logic [7:0] q[$]);
    logic [7:0] x;
    logic [7:0] b;
    q.delete();
    q.push_back(cnt[7:0]);
    q.push_back(cnt[15:8]);
    x = cnt[7:0] ^ cnt[15:8];
    for (int i = 0; i < 4 * cnt; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      x = x ^ b;
    end
    q.push_back(bad ? ~x : x);
    for (int i = 0; i < extra; i++) q.push_back(8'($urandom));
  endtask

  // Model: parse the stream by its format rules and compare the whole outcome.
  task automatic run_stream(input string tag, input logic [7:0] s[$], input int gap_pct,
                            input bit rst_first, input bit timing);
    int         cnt, nw, exp_acc;
    logic [7:0] x;
    bit         exp_done;
    if (rst_first) do_reset();
    seen.delete();
    acc_cyc.delete();
    foreach (s[i]) drive_byte(s[i], gap_pct);
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;

    cnt = int'(s[0]) + 256 * int'(s[1]);
    if (cnt > MAXW) begin
      nw = 0;
      exp_acc = 2;
      exp_done = 1'b0;
    end else begin
      nw = cnt;
      exp_acc = 2 + 4 * cnt + 1;
      x = 8'h00;
      for (int i = 0; i < 2 + 4 * cnt; i++) x = x ^ s[i];
      exp_done = (s[2 + 4 * cnt] == x);
    end

    check({tag, "_done"},     64'(done),           64'(exp_done));
    check({tag, "_cpu_run"},  64'(cpu_run),        64'(exp_done));
    check({tag, "_err"},      64'(err),            64'(!exp_done));
    check({tag, "_in_ready"}, 64'(bus.in_ready),   64'(0));
    check({tag, "_accepted"}, 64'(acc_cyc.size()), 64'(exp_acc));
    check({tag, "_nwrites"},  64'(seen.size()),    64'(nw));
    for (int i = 0; i < nw && i < seen.size(); i++) begin
      int k = 2 + 4 * i;
      check($sformatf("%s_addr%0d", tag, i), 64'(seen[i].addr), 64'(BASE + 32'(4 * i)));
      check($sformatf("%s_data%0d", tag, i), 64'(seen[i].data),
            64'({s[k+3], s[k+2], s[k+1], s[k]}));
      if (k + 3 < acc_cyc.size())
        check($sformatf("%s_wcyc%0d", tag, i), 64'(seen[i].c), 64'(acc_cyc[k+3] + 1));
      if (timing && i > 0)
        check($sformatf("%s_spacing%0d", tag, i), 64'(seen[i].c - seen[i-1].c), 64'(4));
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] demo[$];

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    demo = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};

    // Reset state
    #12;
    check_reset_outputs("por");
    check("por_in_ready", 64'(bus.in_ready), 64'(0));
    @(negedge clk);
    #1;
    reset = 1'b1;

    // One-word program with literal expectations
    run_stream("one_word", demo, 0, 1'b0, 1'b1);
    if (seen.size() > 0) begin
      check("one_word_lit_addr", 64'(seen[0].addr), 64'(BASE));
      check("one_word_lit_data", 64'(seen[0].data), 64'(32'hDEAD_BEEF));
    end

    // Empty program
    q = '{8'h00, 8'h00, 8'h00};
    run_stream("empty", q, 0, 1'b1, 1'b0);

    // Three words back-to-back
    make_stream(3, 1'b0, 0, q);
    run_stream("three", q, 0, 1'b1, 1'b1);

    // Bad checksum, followed by bytes that must be ignored
    make_stream(2, 1'b1, 3, q);
    run_stream("badsum", q, 0, 1'b1, 1'b1);

    // Count one over the limit, then exactly at the limit
    q = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
    run_stream("over_max", q, 0, 1'b1, 1'b0);
    make_stream(MAXW, 1'b0, 0, q);
    run_stream("at_max", q, 0, 1'b1, 1'b1);

    // Reset mid-load, then resend with valid gaps
    do_reset();
    for (int i = 0; i < 4; i++) drive_byte(demo[i], 0);
    @(negedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst_a");
    @(negedge clk);
    #1;
    check_reset_outputs("midrst_b");
    bus.in_valid = 1'b0;
    reset = 1'b1;
    run_stream("resend", demo, 40, 1'b0, 1'b0);

    // Randomized programs
    for (int t = 0; t < 6; t++) begin
      make_stream(int'($urandom_range(0, 6)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 2)), q);
      run_stream($sformatf("rand%0d", t), q, int'($urandom_range(0, 40)), 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
